rc4_prga_engine: RTL and testbench

//  Parametrised RC4 PRGA decrypt engine; successor to the fixed-length decryptor.

---
 rtl/rc4_pkg.sv | 29 ++
 rtl/rc4_lat_wait.sv | 37 +++
 rtl/rc4_prga_engine.sv | 212 +++++++++++++++++++++
 tb/tb_rc4_prga_engine.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 engine types: PRGA state encoding and the plaintext character-window test.
// Also used by the key-search controller.
package rc4_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_INC_I,
    ST_WAIT_SI,
    ST_RD_SI,
    ST_WAIT_SJ,
    ST_RD_SJ,
    ST_WR_SI,
    ST_WR_SJ,
    ST_RD_F,
    ST_WAIT_F,
    ST_WR_P,
    ST_DONE
  } state_t;

  // Operands are zero-extended by the caller, so any byte width up to 32 bits works.
  // An inverted window (lo > hi) leaves only the extra byte acceptable.
  function automatic logic in_window(input logic [31:0] b,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi,
                                     input logic [31:0] extra);
    return ((b >= lo) && (b <= hi)) || (b == extra);
  endfunction

endpackage

// File: rtl/rc4_lat_wait.sv
// Loadable down-counter that stretches a RAM read across RD_LAT cycles.
// last is high in the final wait cycle, letting the FSM advance to the read state.
module rc4_lat_wait #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != {CNT_W{1'b0}}) begin
      cnt_d = cnt_q - 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/rc4_prga_engine.sv
// RC4 PRGA decrypt engine: walks the initialised S-box, writes plaintext, and
// range-checks each byte, reporting the first rejected index.
module rc4_prga_engine
  import rc4_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int S_ADDR_W   = 8,
  parameter int MSG_ADDR_W = 5,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [MSG_ADDR_W:0]   msg_len,
  input  logic                  chk_en,
  input  logic [DATA_W-1:0]     chk_lo,
  input  logic [DATA_W-1:0]     chk_hi,
  input  logic [DATA_W-1:0]     chk_extra,
  output logic [S_ADDR_W-1:0]   s_addr,
  output logic [DATA_W-1:0]     s_wdata,
  output logic                  s_wren,
  input  logic [DATA_W-1:0]     s_rdata,
  output logic [MSG_ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0]     c_rdata,
  output logic [MSG_ADDR_W-1:0] p_addr,
  output logic [DATA_W-1:0]     p_wdata,
  output logic                  p_wren,
  output logic                  busy,
  output logic                  done,
  output logic                  success,
  output logic [MSG_ADDR_W-1:0] fail_idx
);

  localparam bit                HAS_WAIT  = (RD_LAT > 1);
  localparam logic [1:0]        WAIT_LOAD = 2'(RD_LAT - 1);
  localparam logic [MSG_ADDR_W:0] MAX_LEN = {1'b1, {MSG_ADDR_W{1'b0}}};

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d;
  logic [MSG_ADDR_W-1:0] k_q, k_d, fail_idx_q, fail_idx_d;
  logic [MSG_ADDR_W:0]   len_q, len_d, len_clamped;
  logic                  chk_en_q, chk_en_d, success_q, success_d;
  logic [DATA_W-1:0]     lo_q, lo_d, hi_q, hi_d, extra_q, extra_d;
  logic                  wait_load, wait_last;
  logic [DATA_W-1:0]     byte_s;

  rc4_lat_wait #(.CNT_W(2)) u_lat_wait (
    .clk      (clk),
    .reset    (reset),
    .load     (wait_load),
    .load_val (WAIT_LOAD),
    .last     (wait_last)
  );

  assign len_clamped = (msg_len > MAX_LEN) ? MAX_LEN : msg_len;
  assign byte_s      = s_rdata ^ c_rdata;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    si_d       = si_q;
    sj_d       = sj_q;
    k_d        = k_q;
    len_d      = len_q;
    chk_en_d   = chk_en_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    extra_d    = extra_q;
    success_d  = success_q;
    fail_idx_d = fail_idx_q;
    wait_load  = 1'b0;
    s_addr     = {S_ADDR_W{1'b0}};
    s_wdata    = {DATA_W{1'b0}};
    s_wren     = 1'b0;
    p_wdata    = {DATA_W{1'b0}};
    p_wren     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d      = len_clamped;
          chk_en_d   = chk_en;
          lo_d       = chk_lo;
          hi_d       = chk_hi;
          extra_d    = chk_extra;
          i_d        = {DATA_W{1'b0}};
          j_d        = {DATA_W{1'b0}};
          k_d        = {MSG_ADDR_W{1'b0}};
          fail_idx_d = {MSG_ADDR_W{1'b0}};
          if (len_clamped == {(MSG_ADDR_W+1){1'b0}}) begin
            success_d = 1'b1;
            state_d   = ST_DONE;
          end else begin
            success_d = 1'b0;
            state_d   = ST_INC_I;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INC_I: begin
        i_d       = i_q + 1'b1;
        s_addr    = S_ADDR_W'(i_q + 1'b1);
        wait_load = 1'b1;
        state_d   = HAS_WAIT ? ST_WAIT_SI : ST_RD_SI;
      end
      // Wait states keep the issued address on the bus until the read returns.
      ST_WAIT_SI: begin
        s_addr  = S_ADDR_W'(i_q);
        state_d = wait_last ? ST_RD_SI : ST_WAIT_SI;
      end
      ST_RD_SI: begin
        si_d      = s_rdata;
        j_d       = j_q + s_rdata;
        s_addr    = S_ADDR_W'(j_q + s_rdata);
        wait_load = 1'b1;
        state_d   = HAS_WAIT ? ST_WAIT_SJ : ST_RD_SJ;
      end
      ST_WAIT_SJ: begin
        s_addr  = S_ADDR_W'(j_q);
        state_d = wait_last ? ST_RD_SJ : ST_WAIT_SJ;
      end
      ST_RD_SJ: begin
        sj_d    = s_rdata;
        state_d = ST_WR_SI;
      end
      ST_WR_SI: begin
        s_addr  = S_ADDR_W'(i_q);
        s_wdata = sj_q;
        s_wren  = 1'b1;
        state_d = ST_WR_SJ;
      end
      ST_WR_SJ: begin
        s_addr  = S_ADDR_W'(j_q);
        s_wdata = si_q;
        s_wren  = 1'b1;
        state_d = ST_RD_F;
      end
      ST_RD_F: begin
        s_addr    = S_ADDR_W'(si_q + sj_q);
        wait_load = 1'b1;
        state_d   = HAS_WAIT ? ST_WAIT_F : ST_WR_P;
      end
      ST_WAIT_F: begin
        s_addr  = S_ADDR_W'(si_q + sj_q);
        state_d = wait_last ? ST_WR_P : ST_WAIT_F;
      end
      // A rejected byte is still written so the caller can inspect it.
      ST_WR_P: begin
        p_wdata = byte_s;
        p_wren  = 1'b1;
        if (chk_en_q && !in_window(32'(byte_s), 32'(lo_q), 32'(hi_q), 32'(extra_q))) begin
          fail_idx_d = k_q;
          success_d  = 1'b0;
          state_d    = ST_DONE;
        end else if ({1'b0, k_q} == (len_q - 1'b1)) begin
          success_d = 1'b1;
          state_d   = ST_DONE;
        end else begin
          k_d     = k_q + 1'b1;
          state_d = ST_INC_I;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      i_q        <= {DATA_W{1'b0}};
      j_q        <= {DATA_W{1'b0}};
      si_q       <= {DATA_W{1'b0}};
      sj_q       <= {DATA_W{1'b0}};
      k_q        <= {MSG_ADDR_W{1'b0}};
      len_q      <= {(MSG_ADDR_W+1){1'b0}};
      chk_en_q   <= 1'b0;
      lo_q       <= {DATA_W{1'b0}};
      hi_q       <= {DATA_W{1'b0}};
      extra_q    <= {DATA_W{1'b0}};
      success_q  <= 1'b0;
      fail_idx_q <= {MSG_ADDR_W{1'b0}};
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      k_q        <= k_d;
      len_q      <= len_d;
      chk_en_q   <= chk_en_d;
      lo_q       <= lo_d;
      hi_q       <= hi_d;
      extra_q    <= extra_d;
      success_q  <= success_d;
      fail_idx_q <= fail_idx_d;
    end
  end

  assign c_addr   = k_q;
  assign p_addr   = k_q;
  assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign done     = (state_q == ST_DONE);
  assign success  = success_q;
  assign fail_idx = fail_idx_q;

endmodule

// File: tb/tb_rc4_prga_engine.sv
// Directed bench: one engine with single-cycle RAM reads and one with 3-cycle reads,
// driven in lock-step and checked against a software RC4 model and chosen plaintexts.
module tb_rc4_prga_engine;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [5:0] msg_len = 6'd0;
  logic       chk_en = 1'b0;
  logic [7:0] chk_lo = 8'd0, chk_hi = 8'd0, chk_extra = 8'd0;

  logic [7:0] s_addr1, s_wdata1, s_rdata1, c_rdata1, p_wdata1;
  logic [4:0] c_addr1, p_addr1, fail_idx1;
  logic       s_wren1, p_wren1, busy1, done1, success1;
  logic [7:0] s_addr3, s_wdata3, s_rdata3, c_rdata3, p_wdata3;
  logic [4:0] c_addr3, p_addr3, fail_idx3;
  logic       s_wren3, p_wren3, busy3, done3, success3;

  always #5 clk = ~clk;

  rc4_prga_engine #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .msg_len(msg_len), .chk_en(chk_en),
    .chk_lo(chk_lo), .chk_hi(chk_hi), .chk_extra(chk_extra),
    .s_addr(s_addr1), .s_wdata(s_wdata1), .s_wren(s_wren1), .s_rdata(s_rdata1),
    .c_addr(c_addr1), .c_rdata(c_rdata1), .p_addr(p_addr1), .p_wdata(p_wdata1),
    .p_wren(p_wren1), .busy(busy1), .done(done1), .success(success1), .fail_idx(fail_idx1)
  );

  rc4_prga_engine #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start), .msg_len(msg_len), .chk_en(chk_en),
    .chk_lo(chk_lo), .chk_hi(chk_hi), .chk_extra(chk_extra),
    .s_addr(s_addr3), .s_wdata(s_wdata3), .s_wren(s_wren3), .s_rdata(s_rdata3),
    .c_addr(c_addr3), .c_rdata(c_rdata3), .p_addr(p_addr3), .p_wdata(p_wdata3),
    .p_wren(p_wren3), .busy(busy3), .done(done3), .success(success3), .fail_idx(fail_idx3)
  );

  // RAM models, pulse counters and run preparation
  logic [7:0] s_init [256];
  logic [7:0] c_mem  [32];
  logic [7:0] s_mem1 [256], s_mem3 [256], p_mem1 [32], p_mem3 [32];
  logic [7:0] s_rd1, c_rd1, s_p3 [3], c_p3 [3];
  logic       prep_req = 1'b0;
  int         pw1, pw3, sw1, sw3, dn1, dn3, overlap;

  always @(posedge clk) begin
    if (prep_req) begin
      for (int a = 0; a < 256; a++) begin
        s_mem1[a] <= s_init[a];
        s_mem3[a] <= s_init[a];
      end
      for (int a = 0; a < 32; a++) begin
        p_mem1[a] <= 8'd0;
        p_mem3[a] <= 8'd0;
      end
      pw1 <= 0; pw3 <= 0; sw1 <= 0; sw3 <= 0; dn1 <= 0; dn3 <= 0; overlap <= 0;
    end else begin
      if (s_wren1) s_mem1[s_addr1] <= s_wdata1;
      if (s_wren3) s_mem3[s_addr3] <= s_wdata3;
      if (p_wren1) p_mem1[p_addr1] <= p_wdata1;
      if (p_wren3) p_mem3[p_addr3] <= p_wdata3;
      pw1 <= pw1 + int'(p_wren1);
      pw3 <= pw3 + int'(p_wren3);
      sw1 <= sw1 + int'(s_wren1);
      sw3 <= sw3 + int'(s_wren3);
      dn1 <= dn1 + int'(done1);
      dn3 <= dn3 + int'(done3);
      overlap <= overlap + int'(s_wren1 & p_wren1) + int'(s_wren3 & p_wren3);
    end
    s_rd1   <= s_mem1[s_addr1];
    c_rd1   <= c_mem[c_addr1];
    s_p3[0] <= s_mem3[s_addr3];
    s_p3[1] <= s_p3[0];
    s_p3[2] <= s_p3[1];
    c_p3[0] <= c_mem[c_addr3];
    c_p3[1] <= c_p3[0];
    c_p3[2] <= c_p3[1];
  end

  assign s_rdata1 = s_rd1;
  assign c_rdata1 = c_rd1;
  assign s_rdata3 = s_p3[2];
  assign c_rdata3 = c_p3[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Software RC4 reference, key 00 01 02 (key byte at position a is a mod 3)
  logic [7:0] m_s [256];
  logic [7:0] m_i, m_j;
  logic [7:0] pt [32];

  task automatic model_ksa();
    logic [7:0] j, t;
    for (int a = 0; a < 256; a++) m_s[a] = 8'(a);
    j = 8'd0;
    for (int a = 0; a < 256; a++) begin
      j = j + m_s[a] + 8'(a % 3);
      t = m_s[a]; m_s[a] = m_s[j]; m_s[j] = t;
    end
    m_i = 8'd0;
    m_j = 8'd0;
  endtask

  task automatic model_byte(output logic [7:0] z);
    logic [7:0] t, idx;
    m_i = m_i + 8'd1;
    m_j = m_j + m_s[m_i];
    t = m_s[m_i]; m_s[m_i] = m_s[m_j]; m_s[m_j] = t;
    idx = m_s[m_i] + m_s[m_j];
    z = m_s[idx];
  endtask

  // Ciphertext is built so that a correct decrypt yields pt[]
  task automatic prep(input int n);
    logic [7:0] z;
    model_ksa();
    for (int a = 0; a < 256; a++) s_init[a] = m_s[a];
    for (int b = 0; b < n; b++) begin
      model_byte(z);
      c_mem[b] = z ^ pt[b];
    end
    prep_req = 1'b1;
    @(posedge clk); #1;
    prep_req = 1'b0;
  endtask

  int         t1, t3;
  logic       succ1, succ3;
  logic [4:0] fi1, fi3;
  logic [7:0] first_saddr1;

  // t1/t3 count edges from the edge that samples start to the first cycle with done high
  task automatic run(input logic [5:0] len, input logic ce, input logic [7:0] lo,
                     input logic [7:0] hi, input logic [7:0] ex,
                     input int pulse_at, input bit pulse_done);
    int n;
    msg_len = len; chk_en = ce; chk_lo = lo; chk_hi = hi; chk_extra = ex;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    first_saddr1 = s_addr1;
    n = 1; t1 = 0; t3 = 0;
    while (n < 4000) begin
      if (done1 && t1 == 0) begin
        t1 = n; succ1 = success1; fi1 = fail_idx1;
        if (pulse_done) start = 1'b1;
      end
      if (done3 && t3 == 0) begin
        t3 = n; succ3 = success3; fi3 = fail_idx3;
      end
      if (t1 != 0 && t3 != 0) break;
      if (n == pulse_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      n++;
    end
    start = 1'b0;
  endtask

  task automatic check_pt(input string tag, input int n);
    int mm1, mm3;
    mm1 = 0; mm3 = 0;
    for (int b = 0; b < n; b++) begin
      if (p_mem1[b] !== pt[b]) mm1++;
      if (p_mem3[b] !== pt[b]) mm3++;
    end
    check_eq({tag, "_pt_lat1"}, mm1, 0);
    check_eq({tag, "_pt_lat3"}, mm3, 0);
  endtask

  initial begin
    int mm;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_s_wren", {s_wren1, s_wren3}, 2'b00);
    check_eq("rst_p_wren", {p_wren1, p_wren3}, 2'b00);
    check_eq("rst_busy_done", {busy1, done1, busy3, done3}, 4'b0000);
    check_eq("rst_success_fidx", {success1, fail_idx1, success3, fail_idx3}, 12'h000);
    check_eq("rst_addr", {s_addr1, c_addr1, p_addr1, p_wdata1}, 26'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Plain decrypt, no check
    pt[0] = 8'hDE; pt[1] = 8'hAD; pt[2] = 8'hBE; pt[3] = 8'hEF;
    prep(4);
    run(6'd4, 1'b0, 8'd0, 8'd0, 8'd0, -1, 1'b0);
    check_eq("plain_done_lat1", t1, 1 + 4 * 7);
    check_eq("plain_done_lat3", t3, 1 + 4 * 13);
    check_eq("plain_success", {succ1, succ3}, 2'b11);
    check_eq("plain_pwren_lat1", pw1, 4);
    check_eq("plain_pwren_lat3", pw3, 4);
    check_pt("plain", 4);
    mm = 0;
    for (int a = 0; a < 256; a++) if (s_mem1[a] !== m_s[a]) mm++;
    check_eq("plain_sbox_model", mm, 0);
    mm = 0;
    for (int a = 0; a < 256; a++) if (s_mem3[a] !== s_mem1[a]) mm++;
    check_eq("plain_sbox_lat3", mm, 0);
    check_eq("plain_overlap", overlap, 0);

    // Window check rejects '!' at index 2
    pt[0] = "a"; pt[1] = "b"; pt[2] = "!"; pt[3] = "d";
    prep(4);
    run(6'd4, 1'b1, 8'd97, 8'd122, 8'd32, -1, 1'b0);
    check_eq("rej_done_lat1", t1, 1 + 3 * 7);
    check_eq("rej_done_lat3", t3, 1 + 3 * 13);
    check_eq("rej_success", {succ1, succ3}, 2'b00);
    check_eq("rej_fidx", {fi1, fi3}, {5'd2, 5'd2});
    check_eq("rej_pwren", {pw1[7:0], pw3[7:0]}, {8'd3, 8'd3});
    check_pt("rej", 3);

    // Window edges and the extra byte are all accepted
    pt[0] = 8'd97; pt[1] = 8'd122; pt[2] = 8'd32; pt[3] = 8'd97;
    prep(4);
    run(6'd4, 1'b1, 8'd97, 8'd122, 8'd32, -1, 1'b0);
    check_eq("edge_success", {succ1, succ3}, 2'b11);
    check_eq("edge_pwren", pw1, 4);

    // Inverted window: only the extra byte passes
    pt[0] = 8'd32; pt[1] = 8'd32; pt[2] = 8'hF0; pt[3] = 8'd32;
    prep(4);
    run(6'd4, 1'b1, 8'd200, 8'd10, 8'd32, -1, 1'b0);
    check_eq("inv_success", {succ1, succ3}, 2'b00);
    check_eq("inv_fidx", fi1, 5'd2);

    // Zero-length message
    prep(0);
    run(6'd0, 1'b0, 8'd0, 8'd0, 8'd0, -1, 1'b0);
    check_eq("zero_done", {t1[7:0], t3[7:0]}, {8'd1, 8'd1});
    check_eq("zero_success", {succ1, succ3}, 2'b11);
    check_eq("zero_no_writes", sw1 + sw3 + pw1 + pw3, 0);

    // Reset during WR_SJ of byte 2 (edge 1 + 2*7 + 4 after the start edge)
    pt[0] = 8'h11; pt[1] = 8'h22; pt[2] = 8'h33; pt[3] = 8'h44;
    prep(4);
    msg_len = 6'd4; chk_en = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (18) @(posedge clk);
    #1;
    check_eq("mid_wr_sj_seen", s_wren1, 1'b1);
    reset = 1'b1;
    @(posedge clk); #1;
    check_eq("mid_rst_wren", {s_wren1, p_wren1, s_wren3, p_wren3}, 4'b0000);
    check_eq("mid_rst_busy", {busy1, busy3, done1, done3}, 4'b0000);
    check_eq("mid_rst_addr", {s_addr1, s_addr3, success1, fail_idx1}, 22'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check_eq("mid_no_done", dn1 + dn3, 0);
    prep(4);
    run(6'd4, 1'b0, 8'd0, 8'd0, 8'd0, -1, 1'b0);
    check_eq("rerun_first_saddr", first_saddr1, 8'd1);
    check_eq("rerun_done_lat1", t1, 1 + 4 * 7);
    check_pt("rerun", 4);

    // start pulses while busy and on the done cycle are ignored
    pt[0] = 8'h5A; pt[1] = 8'hA5; pt[2] = 8'h00; pt[3] = 8'hFF;
    prep(4);
    run(6'd4, 1'b0, 8'd0, 8'd0, 8'd0, 5, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("ign_done_lat1", t1, 1 + 4 * 7);
    check_eq("ign_one_done", {dn1[7:0], dn3[7:0]}, {8'd1, 8'd1});
    check_eq("ign_idle", {busy1, busy3}, 2'b00);
    check_eq("ign_pwren", pw1 + pw3, 8);
    check_pt("ign", 4);

    // Oversized length clamps to 32 bytes
    for (int b = 0; b < 32; b++) pt[b] = 8'(b * 7 + 3);
    prep(32);
    run(6'd40, 1'b0, 8'd0, 8'd0, 8'd0, -1, 1'b0);
    check_eq("clamp_done_lat1", t1, 1 + 32 * 7);
    check_eq("clamp_pwren", {pw1[7:0], pw3[7:0]}, {8'd32, 8'd32});
    check_pt("clamp", 32);
    check_eq("clamp_overlap", overlap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
